// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 channel multiplexer with manual select and round-robin auto-scan.
// out_o, cur_sel_o and valid_o are all loaded from the same next-channel value at each enabled edge.
module mux_scan_nx1 #(
  parameter int N_CH  = 5,
  parameter int WIDTH = 1,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic                    mode_i,
  input  logic                    load_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [N_CH*WIDTH-1:0]   in_bus_i,
  output logic [WIDTH-1:0]        out_o,
  output logic [SEL_W-1:0]        cur_sel_o,
  output logic                    valid_o,
  output logic                    wrap_o
);

  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  CH_LAST    = SEL_W'(N_CH - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ch_q, ch_d, ch_next;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [WIDTH-1:0]    out_q, out_d, lane;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MANUAL;
      ch_q    <= '0;
      dcnt_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dcnt_q  <= dcnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  // The first scan cycle after leaving MANUAL only restarts the dwell count;
  // a channel whose index is out of range falls back to 0 at its first advance.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dcnt_d  = dcnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    ch_next = ch_q;
    lane    = '0;

    if (en_i) begin
      if (!mode_i) begin
        state_d = MANUAL;
        dcnt_d  = '0;
        if (load_i) begin
          ch_next = sel_i;
        end
      end else if (state_q == MANUAL) begin
        state_d = SCAN;
        dcnt_d  = '0;
      end else if (dcnt_q == DWELL_LAST) begin
        dcnt_d  = '0;
        ch_next = (ch_q >= CH_LAST) ? '0 : ch_q + SEL_W'(1);
        wrap_d  = (ch_next == '0);
      end else begin
        dcnt_d  = dcnt_q + DCNT_W'(1);
      end
    end

    for (int k = 0; k < N_CH; k++) begin
      if (ch_next == SEL_W'(k)) begin
        lane = in_bus_i[k*WIDTH +: WIDTH];
      end
    end

    if (en_i) begin
      ch_d    = ch_next;
      out_d   = lane;
      valid_d = (ch_next <= CH_LAST);
    end
  end

  assign out_o     = out_q;
  assign cur_sel_o = ch_q;
  assign valid_o   = valid_q;
  assign wrap_o    = wrap_q;

endmodule
